// File: rtl/cfg_region_pkg.sv
// rtl/cfg_region_pkg.sv - shared types for the region lookup block
package cfg_region_pkg;

    localparam int unsigned MaxRules = 8;
    localparam int unsigned RuleIdxW = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        TBL_EXEC,
        TBL_CACHED,
        TBL_NONIDEM
    } tbl_e;

    typedef struct packed {
        logic exec;
        logic cached;
        logic nonidem;
    } attr_t;

    typedef struct packed {
        logic [31:0]                NrExecuteRegionRules;
        logic [31:0]                NrCachedRegionRules;
        logic [31:0]                NrNonIdempotentRules;
        logic [MaxRules-1:0][63:0]  ExecuteRegionAddrBase;
        logic [MaxRules-1:0][63:0]  ExecuteRegionLength;
        logic [MaxRules-1:0][63:0]  CachedRegionAddrBase;
        logic [MaxRules-1:0][63:0]  CachedRegionLength;
        logic [MaxRules-1:0][63:0]  NonIdempotentAddrBase;
        logic [MaxRules-1:0][63:0]  NonIdempotentLength;
    } cfg_t;

    // One-hot attribute flag for the table a rule belongs to.
    function automatic attr_t tbl_flag(input tbl_e tbl);
        attr_t a;
        a = '0;
        case (tbl)
            TBL_EXEC:    a.exec    = 1'b1;
            TBL_CACHED:  a.cached  = 1'b1;
            TBL_NONIDEM: a.nonidem = 1'b1;
            default:     a         = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cva6_config_pkg.sv
// rtl/cva6_config_pkg.sv - default region rule tables
package cva6_config_pkg;

    import cfg_region_pkg::*;

    function automatic cfg_t build_cfg();
        cfg_t c;
        c = '0;
        c.NrExecuteRegionRules     = 32'd3;
        c.ExecuteRegionAddrBase[0] = 64'h0000_0000;
        c.ExecuteRegionLength[0]   = 64'h0000_1000;
        c.ExecuteRegionAddrBase[1] = 64'h0001_0000;
        c.ExecuteRegionLength[1]   = 64'h0001_0000;
        c.ExecuteRegionAddrBase[2] = 64'h8000_0000;
        c.ExecuteRegionLength[2]   = 64'h4000_0000;
        c.NrCachedRegionRules      = 32'd1;
        c.CachedRegionAddrBase[0]  = 64'h8000_0000;
        c.CachedRegionLength[0]    = 64'h4000_0000;
        // Two non-idempotent rules with zero length: never match.
        c.NrNonIdempotentRules     = 32'd2;
        return c;
    endfunction

    localparam cfg_t cva6_cfg = build_cfg();

endpackage

// File: rtl/cfg_region_rule_match.sv
// rtl/cfg_region_rule_match.sv - single base/length rule comparator
module cfg_region_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] len,
    output logic                 match
);

    // One extra bit so a region ending at the top of the address space is exact.
    logic [AddrWidth:0] limit;

    assign limit = {1'b0, base} + {1'b0, len};
    assign match = (len != '0) && (addr >= base) && ({1'b0, addr} < limit);

endmodule

// File: rtl/cfg_region_lookup.sv
// rtl/cfg_region_lookup.sv - sequential region attribute lookup (optional CFG_REGION_LOOKUP_PERF_EN)
module cfg_region_lookup
    import cfg_region_pkg::*;
#(
    parameter cfg_t        CVA6Cfg   = cva6_config_pkg::cva6_cfg,
    parameter int unsigned AddrWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 query_valid_i,
    output logic                 query_ready_o,
    input  logic [AddrWidth-1:0] query_addr_i,
    input  logic                 flush_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_exec_o,
    output logic                 resp_cached_o,
    output logic                 resp_nonidem_o,
    output logic                 busy_o
`ifdef CFG_REGION_LOOKUP_PERF_EN
    ,
    output logic [31:0]          query_cnt_o
`endif
);

    localparam int unsigned NrExec    = CVA6Cfg.NrExecuteRegionRules;
    localparam int unsigned NrCached  = CVA6Cfg.NrCachedRegionRules;
    localparam int unsigned NrNonidem = CVA6Cfg.NrNonIdempotentRules;
    localparam int unsigned NrRules   = NrExec + NrCached + NrNonidem;
    localparam int unsigned IdxW      = 5;

    state_e                 state_q;
    logic [IdxW-1:0]        idx_q;
    logic [AddrWidth-1:0]   addr_q;
    attr_t                  flags_q;
    logic                   resp_valid_q;
    logic                   busy_q;
    logic                   ready_q;

    // Rule operands are registered before the compare, so the scan runs one
    // cycle behind the index: N+1 edges from accept to response.
    logic                   pipe_valid_q;
    logic [AddrWidth-1:0]   pipe_base_q;
    logic [AddrWidth-1:0]   pipe_len_q;
    tbl_e                   pipe_tbl_q;

    logic [RuleIdxW-1:0]    lidx;
    logic [AddrWidth-1:0]   rule_base;
    logic [AddrWidth-1:0]   rule_len;
    tbl_e                   rule_tbl;
    logic                   match;
    attr_t                  hit;

    always_comb begin
        lidx     = '0;
        rule_tbl = TBL_EXEC;
        if (32'(idx_q) < NrExec) begin
            lidx     = RuleIdxW'(idx_q);
            rule_tbl = TBL_EXEC;
        end else if (32'(idx_q) < NrExec + NrCached) begin
            lidx     = RuleIdxW'(idx_q - IdxW'(NrExec));
            rule_tbl = TBL_CACHED;
        end else begin
            lidx     = RuleIdxW'(idx_q - IdxW'(NrExec + NrCached));
            rule_tbl = TBL_NONIDEM;
        end
    end

    always_comb begin
        rule_base = '0;
        rule_len  = '0;
        case (rule_tbl)
            TBL_EXEC: begin
                rule_base = AddrWidth'(CVA6Cfg.ExecuteRegionAddrBase[lidx]);
                rule_len  = AddrWidth'(CVA6Cfg.ExecuteRegionLength[lidx]);
            end
            TBL_CACHED: begin
                rule_base = AddrWidth'(CVA6Cfg.CachedRegionAddrBase[lidx]);
                rule_len  = AddrWidth'(CVA6Cfg.CachedRegionLength[lidx]);
            end
            TBL_NONIDEM: begin
                rule_base = AddrWidth'(CVA6Cfg.NonIdempotentAddrBase[lidx]);
                rule_len  = AddrWidth'(CVA6Cfg.NonIdempotentLength[lidx]);
            end
            default: begin
                rule_base = '0;
                rule_len  = '0;
            end
        endcase
    end

    cfg_region_rule_match #(
        .AddrWidth(AddrWidth)
    ) u_rule_match (
        .addr (addr_q),
        .base (pipe_base_q),
        .len  (pipe_len_q),
        .match(match)
    );

    always_comb begin
        hit = '0;
        if (pipe_valid_q && match) begin
            hit = tbl_flag(pipe_tbl_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            flags_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            pipe_valid_q <= 1'b0;
            pipe_base_q  <= '0;
            pipe_len_q   <= '0;
            pipe_tbl_q   <= TBL_EXEC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (query_valid_i && ready_q && !flush_i) begin
                        addr_q       <= query_addr_i;
                        flags_q      <= '0;
                        idx_q        <= '0;
                        pipe_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        ready_q      <= 1'b0;
                        if (NrRules == 0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (flush_i) begin
                        state_q      <= IDLE;
                        pipe_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ready_q      <= 1'b1;
                    end else begin
                        flags_q <= flags_q | hit;
                        if (32'(idx_q) < NrRules) begin
                            pipe_base_q  <= rule_base;
                            pipe_len_q   <= rule_len;
                            pipe_tbl_q   <= rule_tbl;
                            pipe_valid_q <= 1'b1;
                            idx_q        <= idx_q + 1'b1;
                        end else begin
                            pipe_valid_q <= 1'b0;
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (flush_i || resp_ready_i) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    ready_q      <= 1'b1;
                end
            endcase
        end
    end

`ifdef CFG_REGION_LOOKUP_PERF_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == RESP && resp_valid_q && resp_ready_i && !flush_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign query_cnt_o = cnt_q;
`endif

    assign query_ready_o  = ready_q;
    assign busy_o         = busy_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_exec_o    = resp_valid_q & flags_q.exec;
    assign resp_cached_o  = resp_valid_q & flags_q.cached;
    assign resp_nonidem_o = resp_valid_q & flags_q.nonidem;

endmodule

// File: tb/tb_cfg_region_lookup.sv
// tb/tb_cfg_region_lookup.sv - directed self-checking bench for cfg_region_lookup
module tb_cfg_region_lookup;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        query_valid = 1'b0;
    logic        query_ready;
    logic [63:0] query_addr = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_exec;
    logic        resp_cached;
    logic        resp_nonidem;
    logic        busy;
`ifdef CFG_REGION_LOOKUP_PERF_EN
    logic [31:0] query_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfg_region_lookup #(
        .AddrWidth(64)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .query_valid_i (query_valid),
        .query_ready_o (query_ready),
        .query_addr_i  (query_addr),
        .flush_i       (flush),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_exec_o   (resp_exec),
        .resp_cached_o (resp_cached),
        .resp_nonidem_o(resp_nonidem),
        .busy_o        (busy)
`ifdef CFG_REGION_LOOKUP_PERF_EN
        ,
        .query_cnt_o   (query_cnt)
`endif
    );

    // Issues one query and waits (bounded) for the response; lat = -1 on timeout.
    task automatic do_query(input logic [63:0] a, input logic rdy,
                            output int lat, output logic [2:0] attr);
        @(posedge clk); #1;
        resp_ready  = rdy;
        query_addr  = a;
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        lat  = -1;
        attr = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat  = i;
                attr = {resp_exec, resp_cached, resp_nonidem};
                break;
            end
        end
        if (rdy && lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold valid/busy got=%b%b exp=00", resp_valid, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (query_ready !== 1'b1 || busy !== 1'b0 || resp_exec !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready/busy/exec got=%b%b%b exp=100",
                     query_ready, busy, resp_exec);
        end
    endtask

    task automatic test_main();
        int lat;
        logic [2:0] attr;
        do_query(64'h8000_1000, 1'b1, lat, attr);
        total++;
        if (lat !== 7) begin
            bad++;
            $display("FAIL main_latency got=%0d exp=7", lat);
        end
        total++;
        if (attr !== 3'b110) begin
            bad++;
            $display("FAIL main_attr got=%b exp=110", attr);
        end
        total++;
        if (query_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL main_return_idle ready/valid got=%b%b exp=10", query_ready, resp_valid);
        end
    endtask

    task automatic test_bounds();
        logic [63:0] addrs [7];
        logic [2:0]  exps  [7];
        int lat;
        logic [2:0] attr;
        addrs = '{64'h0FFF, 64'h1000, 64'hC000_0000, 64'h0, 64'hBFFF_FFFF, 64'h1_FFFF, 64'h2_0000};
        exps  = '{3'b100,   3'b000,   3'b000,        3'b100, 3'b110,       3'b100,     3'b000};
        for (int i = 0; i < 7; i++) begin
            do_query(addrs[i], 1'b1, lat, attr);
            total++;
            if (attr !== exps[i] || lat !== 7) begin
                bad++;
                $display("FAIL bounds addr=%0h got attr=%b lat=%0d exp attr=%b lat=7",
                         addrs[i], attr, lat, exps[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2:0] attr;
        int unstable;
        do_query(64'h1_0004, 1'b0, lat, attr);
        total++;
        if (lat !== 7 || attr !== 3'b100) begin
            bad++;
            $display("FAIL bp_first got lat=%0d attr=%b exp lat=7 attr=100", lat, attr);
        end
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || {resp_exec, resp_cached, resp_nonidem} !== 3'b100 ||
                query_ready !== 1'b0 || busy !== 1'b1)
                unstable++;
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL bp_hold unstable_cycles got=%0d exp=0", unstable);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (query_ready !== 1'b1 || resp_valid !== 1'b0 || resp_exec !== 1'b0) begin
            bad++;
            $display("FAIL bp_release ready/valid/exec got=%b%b%b exp=100",
                     query_ready, resp_valid, resp_exec);
        end
    endtask

    task automatic test_flush();
        int seen;
        int lat;
        logic [2:0] attr;
        @(posedge clk); #1;
        resp_ready  = 1'b1;
        query_addr  = 64'h8000_1000;
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_busy_before got=%b exp=1", busy);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || query_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_scan busy/ready/valid got=%b%b%b exp=010",
                     busy, query_ready, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_no_resp got=%0d exp=0", seen);
        end
        // flush while idle must block acceptance
        query_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        flush       = 1'b0;
        total++;
        if (busy !== 1'b0 || query_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle busy/ready got=%b%b exp=01", busy, query_ready);
        end
        // flush beats resp_ready in RESP
        do_query(64'h0, 1'b0, lat, attr);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        total++;
        if (lat !== 7 || resp_valid !== 1'b0 || query_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_resp lat/valid/ready got=%0d/%b/%b exp=7/0/1",
                     lat, resp_valid, query_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2:0] attr;
        @(posedge clk); #1;
        resp_ready  = 1'b1;
        query_addr  = 64'h8000_1000;
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || query_ready !== 1'b1 || resp_exec !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid valid/busy/ready/exec got=%b%b%b%b exp=0010",
                     resp_valid, busy, query_ready, resp_exec);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_query(64'h1_8000, 1'b1, lat, attr);
        total++;
        if (lat !== 7 || attr !== 3'b100) begin
            bad++;
            $display("FAIL rst_fresh got lat=%0d attr=%b exp lat=7 attr=100", lat, attr);
        end
    endtask

`ifdef CFG_REGION_LOOKUP_PERF_EN
    task automatic test_perf();
        int lat;
        logic [2:0] attr;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (query_cnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset got=%0d exp=0", query_cnt);
        end
        for (int i = 0; i < 3; i++) do_query(64'h8000_0000, 1'b1, lat, attr);
        @(posedge clk); #1;
        resp_ready  = 1'b1;
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (query_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_count got=%0d exp=3", query_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_main();
        test_bounds();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef CFG_REGION_LOOKUP_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_region_lookup.md
CFG_REGION_LOOKUP -- requirements
Module: cfg_region_lookup

Interface
REQ-001 SHALL have parameter CVA6Cfg, default cva6_config_pkg::cva6_cfg; it supplies the region rule tables that are scanned.
REQ-002 SHALL have parameter AddrWidth, default 64; it is the width of the query address.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port query_valid_i, input, 1 bit: a query is offered.
REQ-006 SHALL have port query_ready_o, output, 1 bit: the block can accept a query.
REQ-007 SHALL have port query_addr_i, input, AddrWidth bits: the physical address to classify.
REQ-008 SHALL have port flush_i, input, 1 bit: abort any in-flight query.
REQ-009 SHALL have port resp_valid_o, output, 1 bit: the response is valid.
REQ-010 SHALL have port resp_ready_i, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have ports resp_exec_o, resp_cached_o and resp_nonidem_o, outputs, 1 bit each: the region attributes of the query address.
REQ-012 SHALL have port busy_o, output, 1 bit: the FSM is not in IDLE.

Function
REQ-013 SHALL scan the rule tables in this fixed order: Execute rules 0..NrExecuteRegionRules-1, then Cached rules, then NonIdempotent rules; N is the total number of rules.
REQ-014 SHALL treat a rule as matched when base <= addr < base+length, with the sum computed in AddrWidth+1 bits so it cannot overflow.
REQ-015 SHALL never match a rule whose length is 0.
REQ-016 SHALL implement FSM states IDLE, SCAN and RESP.
REQ-017 In IDLE, query_ready_o SHALL be 1; in SCAN and RESP it SHALL be 0.
REQ-018 When query_valid_i && query_ready_o at an edge, the FSM SHALL capture the address, clear the attribute flags, zero the rule index, and go to SCAN; if N==0 it SHALL go directly to RESP with all flags 0.
REQ-019 In SCAN, the FSM SHALL evaluate one rule per cycle, OR the match result into the flag of that rule's table, and increment the index; after rule N-1 it SHALL go to RESP.
REQ-020 Latency from the accept edge to resp_valid_o=1 SHALL be exactly N+1 cycles; scanning SHALL not stop early on a match.
REQ-021 In RESP, resp_valid_o SHALL be 1 and all resp_* outputs SHALL hold stable until resp_valid_o && resp_ready_i at an edge, after which the FSM SHALL return to IDLE.
REQ-022 A new query SHALL be accepted no earlier than the cycle after the response handshake, so there is no back-to-back overlap.
REQ-023 flush_i=1 in SCAN or RESP SHALL return the FSM to IDLE at the next edge with no response issued; flush_i=1 in IDLE SHALL block acceptance in that cycle.
REQ-024 When flush_i and resp_ready_i are both 1 in RESP, flush SHALL win, and the consumer SHALL ignore that response.
REQ-025 resp_* outputs SHALL read 0 whenever resp_valid_o=0.

Reset
REQ-026 While rst_i=1, asynchronously: FSM=IDLE, index=0, flags=0, resp_valid_o=0, busy_o=0, and query_ready_o=1 from the first cycle after deassertion.
REQ-027 Reset asserted mid-SCAN or mid-RESP SHALL drop the query silently.

Configuration
REQ-028 With macro CFG_REGION_LOOKUP_PERF_EN defined, the block SHALL add output query_cnt_o[31:0] that counts completed response handshakes, wraps from 0xFFFF_FFFF to 0, and resets to 0.
REQ-029 Without CFG_REGION_LOOKUP_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The state enum (IDLE/SCAN/RESP) and the attribute struct (exec, cached, nonidem) SHALL live in shared package cfg_region_pkg.
REQ-031 The single-rule comparator SHALL be sub-module cfg_region_rule_match (inputs addr, base, len; output match), instantiated once and time-multiplexed by the index.

Verification (default config: Exec {0x0/0x1000, 0x1_0000/0x1_0000, 0x8000_0000/0x4000_0000}, Cached {0x8000_0000/0x4000_0000}, NonIdem lengths 0, N=6)
REQ-032 Query 0x8000_1000 with resp_ready_i=1 -> resp_valid_o=1 exactly 7 cycles after accept, with exec=1, cached=1, nonidem=0.
REQ-033 Query 0x0FFF -> exec=1; query 0x1000 -> exec=0; query 0xC000_0000 -> all flags 0 (end bound exclusive); query 0x0 -> nonidem=0 (zero-length rules never match).
REQ-034 resp_ready_i held 0 for 5 cycles -> resp_valid_o and attributes stable throughout, query_ready_o=0; handshake -> query_ready_o=1 the next cycle.
REQ-035 flush_i pulsed 3 cycles after accept -> no resp_valid_o ever for that query, busy_o=0 and query_ready_o=1 the next cycle.
REQ-036 rst_i asserted mid-SCAN -> outputs at reset values immediately; a fresh query of 0x1_8000 after release -> exec=1, cached=0.
REQ-037 With CFG_REGION_LOOKUP_PERF_EN defined and 3 completed queries plus 1 flushed query -> query_cnt_o=3.
